// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit hex display scanner.
// A refresh counter paces the digit select. A one-deep pending buffer with
// a ready/valid handshake feeds the active display word, which is replaced
// only at frame boundaries so that no frame is torn.
// Optional feature: define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [31:0] data,
  output logic        data_ready,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  typedef enum logic {EMPTY, PENDING} state_t;

  state_t        state, state_n;
  logic [31:0]   active, active_n;
  logic [31:0]   pending, pending_n;
  logic [CW-1:0] cnt;
  logic [2:0]    sel_n;
  logic          tick;
  logic          frame_edge;

  assign tick       = (cnt == TERM);
  assign frame_edge = tick && (sel == 3'd7);
  assign data_ready = (state == EMPTY);

  // Refresh counter: counts 0..REFRESH_DIV-1 and wraps; the terminal count is the digit tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state, buffer capture, frame-boundary promotion and next digit index.
  // A capture landing on a frame boundary happens in EMPTY, where no promotion
  // is possible, so the new word waits for the next boundary.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    active_n  = active;
    sel_n     = tick ? sel + 3'd1 : sel;
    case (state)
      EMPTY: begin
        if (data_valid) begin
          pending_n = data;
          state_n   = PENDING;
        end
      end
      PENDING: begin
        if (frame_edge) begin
          active_n = pending;
          state_n  = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // Datapath registers. num is computed from the next active word and the
  // next index, which keeps it aligned with sel and shows a newly promoted
  // word starting at digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active      <= '0;
      pending     <= '0;
      sel         <= '0;
      num         <= '0;
      frame_start <= 1'b0;
    end else begin
      active      <= active_n;
      pending     <= pending_n;
      sel         <= sel_n;
      num         <= active_n[{sel_n, 2'b00} +: 4];
      frame_start <= frame_edge;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero blanking: dark when this digit and every more-significant digit are zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank <= 1'b0;
    end else begin
      blank <= (sel_n != 3'd0) && ((active_n >> {sel_n, 2'b00}) == '0);
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with REFRESH_DIV=4: directed scenarios plus
// random traffic, checked against a cycle-count based reference model.
module tb_seg_scan_driver;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        blank;
  logic        frame_start;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: t counts rising edges since reset release; the displayed
  // digit and frame pulses follow directly from t.
  int unsigned t;
  logic [31:0] m_active;
  logic [31:0] m_pend;
  bit          m_has;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .data_ready (data_ready),
    .num        (num),
    .sel        (sel),
    .blank      (blank),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] w, input int unsigned k);
    return 4'((w >> (4 * k)) & 32'hF);
  endfunction

  function automatic logic exp_blank(input logic [31:0] w, input int unsigned s);
`ifdef SEG_SCAN_LZB_EN
    if (s == 0) return 1'b0;
    for (int unsigned k = s; k < 8; k++) begin
      if (nib(w, k) != 4'h0) return 1'b0;
    end
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned exp_sel();
    return (t / DIV) % 8;
  endfunction

  task automatic check_outputs();
    int unsigned s;
    s = exp_sel();
    check_eq("sel", {29'd0, sel}, s);
    check_eq("num", {28'd0, num}, {28'd0, nib(m_active, s)});
    check_eq("blank", {31'd0, blank}, {31'd0, exp_blank(m_active, s)});
    check_eq("frame_start", {31'd0, frame_start}, {31'd0, (t > 0) && (t % FRAME == 0)});
    check_eq("data_ready", {31'd0, data_ready}, {31'd0, !m_has});
  endtask

  // One clock: drive inputs, update the model at the edge, check at the falling edge.
  task automatic step(input logic v, input logic [31:0] d);
    int unsigned nt;
    data_valid = v;
    data       = d;
    @(posedge clk);
    nt = t + 1;
    if (m_has && (nt % FRAME == 0)) begin
      m_active = m_pend;
      m_has    = 1'b0;
    end else if (!m_has && v) begin
      m_pend = d;
      m_has  = 1'b1;
    end
    t = nt;
    @(negedge clk);
    check_outputs();
    data_valid = 1'b0;
  endtask

  task automatic idle_until_phase(input int unsigned ph);
    for (int i = 0; i < 3 * FRAME && (t % FRAME) != ph; i++) step(1'b0, '0);
    check_eq("phase_reached", t % FRAME, ph);
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 3 * FRAME && m_has; i++) step(1'b0, '0);
    step(1'b1, w);
    for (int i = 0; i < 3 * FRAME && m_has; i++) step(1'b0, '0);
    check_eq("load_word", m_active, w);
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data = '0;
    t = 0; m_active = '0; m_pend = '0; m_has = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Idle scanning.
    for (int i = 0; i < 40; i++) step(1'b0, '0);

    // Mid-frame capture, ignored second word while pending, promotion.
    idle_until_phase(10);
    step(1'b1, 32'h76543210);
    step(1'b0, '0);
    step(1'b1, 32'hFFFFFFFF);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, '0);
    check_eq("promoted_first_word", m_active, 32'h76543210);

    // Capture in the exact boundary cycle: old word stays one more frame.
    idle_until_phase(FRAME - 1);
    step(1'b1, 32'h0000ABCD);
    check_eq("boundary_capture_old", m_active, 32'h76543210);
    for (int i = 0; i < FRAME; i++) step(1'b0, '0);
    for (int i = 0; i < FRAME; i++) step(1'b0, '0);
    check_eq("boundary_capture_new", m_active, 32'h0000ABCD);

    // Leading-zero blanking patterns.
    load_word(32'h00000A05);
    for (int i = 0; i < FRAME; i++) step(1'b0, '0);
    load_word(32'h00000000);
    for (int i = 0; i < FRAME; i++) step(1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 1200; i++) begin
      logic [31:0] d;
      d = $urandom >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 5) == 0, d);
    end

    // Reset with a word pending at sel=5.
    load_word(32'h11111111);
    idle_until_phase(2);
    step(1'b1, 32'h89ABCDEF);
    for (int i = 0; i < FRAME && exp_sel() != 5; i++) step(1'b0, '0);
    check_eq("pending_before_reset", {31'd0, m_has}, 32'd1);
    #2 rst = 1'b1;
    #1;
    t = 0; m_active = '0; m_has = 1'b0;
    check_eq("rst_sel", {29'd0, sel}, 32'd0);
    check_eq("rst_num", {28'd0, num}, 32'd0);
    check_eq("rst_blank", {31'd0, blank}, 32'd0);
    check_eq("rst_frame_start", {31'd0, frame_start}, 32'd0);
    check_eq("rst_data_ready", {31'd0, data_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) step(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles each digit is displayed; legal range 2 to 2^24.
REQ-002 SHALL have port clk  input  1  rising-edge system clock, the block's only clock.
REQ-003 SHALL have port rst  input  1  reset: asynchronous and active-high.
REQ-004 SHALL have port data_valid  input  1  producer offers a new 8-digit display word.
REQ-005 SHALL have port data  input  32  eight hex nibbles; nibble k (data[4k+3:4k]) belongs to digit k.
REQ-006 SHALL have port data_ready  output  1  block can accept a display word this cycle.
REQ-007 SHALL have port num  output  4  nibble of the currently selected digit, feeding the segment decoder.
REQ-008 SHALL have port sel  output  3  index of the currently selected digit, feeding the anode decoder.
REQ-009 SHALL have port blank  output  1  the current digit is to be shown dark.
REQ-010 SHALL have port frame_start  output  1  one-cycle pulse when the scan returns to digit 0.

Function
REQ-011 SHALL hold an active display register (32 bits), a pending register (32 bits), a refresh counter of width ceil(log2(REFRESH_DIV)), and a 3-bit digit index.
REQ-012 SHALL increment the refresh counter every cycle from 0 to REFRESH_DIV-1 and wrap to 0; the terminal count (REFRESH_DIV-1) is the digit tick.
REQ-013 SHALL advance sel by 1 modulo 8 on each digit tick (7 -> 0), and hold sel at all other times.
REQ-014 SHALL drive num as a register equal to the active-register nibble for sel; num SHALL update in the same cycle as sel, with no cycle where num and sel disagree.
REQ-015 SHALL implement a two-state FSM: EMPTY (data_ready=1) and PENDING (data_ready=0).
REQ-016 In EMPTY, data_valid=1 SHALL capture data into the pending register and move to PENDING on the next edge; data_valid=0 SHALL leave the state unchanged.
REQ-017 In PENDING, data_valid SHALL be ignored and data SHALL not be sampled.
REQ-018 In PENDING, on the digit tick where sel goes 7 -> 0 (frame boundary), SHALL copy pending into active and return to EMPTY; num for digit 0 SHALL already reflect the new word.
REQ-019 If a capture (REQ-016) and a frame boundary fall in the same cycle, SHALL capture into pending only; promotion SHALL occur at the following frame boundary.
REQ-020 SHALL never change the active register except at a frame boundary, so no frame is torn.
REQ-021 SHALL assert frame_start for exactly the one cycle in which sel first reads 0 after 7.

Reset
REQ-022 While rst=1, SHALL force: active=0, pending=0, counter=0, sel=0, num=0, blank=0, frame_start=0, FSM=EMPTY, data_ready=1.
REQ-023 Reset asserted mid-operation SHALL discard any pending word immediately; after release, scanning SHALL restart at digit 0 with counter=0.
REQ-024 The first digit tick after reset release SHALL occur REFRESH_DIV cycles after the first rising edge with rst=0.

Configuration
REQ-025 With SEG_SCAN_LZB_EN defined, SHALL drive blank=1 when sel>0 and active nibbles sel through 7 are all zero (leading-zero blanking); digit 0 is never blanked; blank SHALL be registered and aligned with sel/num.
REQ-026 Without SEG_SCAN_LZB_EN, blank SHALL be constant 0, and no blanking logic SHALL be synthesized.

Verification (REFRESH_DIV=4)
REQ-027 Reset, then hold data_valid=0 for 40 cycles -> sel steps 0..7 every 4 cycles, num=0 throughout, frame_start pulses once every 32 cycles, data_ready=1.
REQ-028 One-cycle data_valid with data=0x76543210 mid-frame -> data_ready low next cycle; num unchanged until sel 7->0; then num=0,1,...,7 follows sel; data_ready high one cycle after promotion.
REQ-029 Second data_valid with data=0xFFFFFFFF while PENDING -> ignored; the promoted word is the first one (0x76543210).
REQ-030 data_valid with data=0x0000ABCD in the exact cycle sel goes 7->0 -> the old word is shown for one more full frame; the new word is shown from the following frame.
REQ-031 Assert rst with a word pending at sel=5 -> all outputs at reset values within the same cycle; after release, active=0 and the pending word is lost.
REQ-032 With SEG_SCAN_LZB_EN defined and active=0x00000A05 -> blank=0 for sel 0..2, blank=1 for sel 3..7; with active=0 -> blank=1 for sel 1..7 only; without the macro -> blank=0 always.
